// File: rtl/core_pkg.sv
// Shared types for the RV32I multi-cycle controller: state encoding,
// decoder instruction-class struct and trap cause codes.
package core_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALTED,
    ST_TRAP
  } ctrl_state_t;

  typedef struct packed {
    logic alu;
    logic load;
    logic store;
    logic branch;
    logic jump;
  } instr_class_t;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_IMEM_TO = 2'd2;
  localparam logic [1:0] CAUSE_DMEM_TO = 2'd3;

endpackage

// File: rtl/mem_wait_timer.sv
// Memory wait counter: counts stalled cycles and flags the cycle in which the
// wait limit is reached. MEM_TIMEOUT = 0 disables expiry.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 8
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  // Expiry fires during the stalled cycle that brings the count to MEM_TIMEOUT,
  // so a valid arriving in that same cycle is still accepted by the caller.
  localparam logic [CNT_W-1:0] LIMIT = (MEM_TIMEOUT == 0) ? '0 : CNT_W'(MEM_TIMEOUT - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_expired = (MEM_TIMEOUT != 0) && i_enable && (r_cnt == LIMIT);

endmodule

// File: rtl/core_controller.sv
// Multi-cycle sequencer for the RV32I core: fetch, decode, execute, memory, writeback.
// Optional performance counters are built when CORE_CONTROLLER_PERF_EN is defined.
module core_controller
  import core_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        imem_valid,
  input  logic        dmem_valid,
  input  logic        dec_alu,
  input  logic        dec_load,
  input  logic        dec_store,
  input  logic        dec_branch,
  input  logic        dec_jump,
  input  logic        branch_taken,
  input  logic        halt,
  output logic        imem_req,
  output logic        ir_we,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        reg_we,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] perf_cycles,
  output logic [31:0] perf_instret
);

  ctrl_state_t  r_state, w_next;
  instr_class_t r_class, w_dec_class;
  logic         r_taken;
  logic [1:0]   r_cause, w_next_cause;
  logic         w_wait_clear, w_wait_en, w_expired;

  assign w_dec_class = {dec_alu, dec_load, dec_store, dec_branch, dec_jump};

  // Counter is held clear outside FETCH/MEM, which clears it on every entry.
  assign w_wait_clear = !((r_state == ST_FETCH) || (r_state == ST_MEM));
  assign w_wait_en    = ((r_state == ST_FETCH) && !imem_valid) ||
                        ((r_state == ST_MEM)   && !dmem_valid);

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) u_wait (
    .clk      (clk),
    .rstn     (rstn),
    .i_clear  (w_wait_clear),
    .i_enable (w_wait_en),
    .o_expired(w_expired)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_cause <= CAUSE_NONE;
      r_class <= '0;
      r_taken <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cause <= w_next_cause;
      if (r_state == ST_DECODE) r_class <= w_dec_class;
      if (r_state == ST_EXEC)   r_taken <= branch_taken;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_next_cause = r_cause;
    imem_req     = 1'b0;
    ir_we        = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    reg_we       = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = 1'b0;
    trap         = 1'b0;
    unique case (r_state)
      ST_IDLE: w_next = halt ? ST_HALTED : ST_FETCH;
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_valid) begin
          ir_we  = 1'b1;
          w_next = ST_DECODE;
        end else if (w_expired) begin
          w_next       = ST_TRAP;
          w_next_cause = CAUSE_IMEM_TO;
        end
      end
      ST_DECODE: begin
        if ($onehot(w_dec_class)) begin
          w_next = ST_EXEC;
        end else begin
          w_next       = ST_TRAP;
          w_next_cause = CAUSE_ILLEGAL;
        end
      end
      ST_EXEC: w_next = (r_class.load || r_class.store) ? ST_MEM : ST_WB;
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = r_class.store;
        if (dmem_valid) begin
          w_next = ST_WB;
        end else if (w_expired) begin
          w_next       = ST_TRAP;
          w_next_cause = CAUSE_DMEM_TO;
        end
      end
      ST_WB: begin
        pc_we  = 1'b1;
        pc_sel = r_class.jump || (r_class.branch && r_taken);
        reg_we = r_class.alu || r_class.load || r_class.jump;
        w_next = halt ? ST_HALTED : ST_FETCH;
      end
      ST_HALTED: if (!halt) w_next = ST_FETCH;
      ST_TRAP:   trap = 1'b1;
      default:   w_next = ST_IDLE;
    endcase
  end

  assign trap_cause = r_cause;

`ifdef CORE_CONTROLLER_PERF_EN
  logic [31:0] r_perf_cycles, r_perf_instret;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_perf_cycles  <= '0;
      r_perf_instret <= '0;
    end else begin
      if (r_state != ST_TRAP) r_perf_cycles  <= r_perf_cycles + 32'd1;
      if (r_state == ST_WB)   r_perf_instret <= r_perf_instret + 32'd1;
    end
  end

  assign perf_cycles  = r_perf_cycles;
  assign perf_instret = r_perf_instret;
`else
  assign perf_cycles  = '0;
  assign perf_instret = '0;
`endif

endmodule

// File: tb/tb_core_controller.sv
// Directed bench for core_controller: a per-instruction cycle-trace model builds
// the expected output rows, one compare loop checks the DUT every cycle.
module tb_core_controller;

  localparam int unsigned TMO = 4;

  localparam bit [4:0] C_ALU   = 5'b10000;
  localparam bit [4:0] C_LOAD  = 5'b01000;
  localparam bit [4:0] C_STORE = 5'b00100;
  localparam bit [4:0] C_BR    = 5'b00010;
  localparam bit [4:0] C_JMP   = 5'b00001;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic imem_valid = 1'b0, dmem_valid = 1'b0;
  logic dec_alu = 1'b0, dec_load = 1'b0, dec_store = 1'b0, dec_branch = 1'b0, dec_jump = 1'b0;
  logic branch_taken = 1'b0, halt = 1'b0;
  logic imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we, pc_sel, trap;
  logic [1:0]  trap_cause;
  logic [31:0] perf_cycles, perf_instret;

  always #5 clk = ~clk;

  core_controller #(
    .MEM_TIMEOUT(TMO),
    .CNT_W      (8)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .imem_valid  (imem_valid),
    .dmem_valid  (dmem_valid),
    .dec_alu     (dec_alu),
    .dec_load    (dec_load),
    .dec_store   (dec_store),
    .dec_branch  (dec_branch),
    .dec_jump    (dec_jump),
    .branch_taken(branch_taken),
    .halt        (halt),
    .imem_req    (imem_req),
    .ir_we       (ir_we),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .reg_we      (reg_we),
    .pc_we       (pc_we),
    .pc_sel      (pc_sel),
    .trap        (trap),
    .trap_cause  (trap_cause),
    .perf_cycles (perf_cycles),
    .perf_instret(perf_instret)
  );

  // Expected vector: {imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we, pc_sel, trap, cause[1:0]}
  typedef struct {
    bit       iv, dv, tk, hl;
    bit [4:0] cls;
    bit [9:0] exp;
  } row_t;

  row_t         q[$];
  logic [9:0]   obs[$];
  int           tests = 0;
  int           fails = 0;
  bit   [31:0]  m_cycles = 0;
  bit   [31:0]  m_instret = 0;

  function automatic bit [9:0] ev(bit ireq, bit irwe, bit dreq, bit dwe, bit rwe,
                                  bit pcwe, bit pcsel, bit trp, bit [1:0] cause);
    return {ireq, irwe, dreq, dwe, rwe, pcwe, pcsel, trp, cause};
  endfunction

  function automatic logic [9:0] outv();
    return {imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we, pc_sel, trap, trap_cause};
  endfunction

  task automatic push(bit iv, bit dv, bit tk, bit hl, bit [4:0] cls, bit [9:0] e);
    row_t r;
    r.iv = iv; r.dv = dv; r.tk = tk; r.hl = hl; r.cls = cls; r.exp = e;
    q.push_back(r);
  endtask

  task automatic check1(string name, logic a, bit e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %b expected %b", name, a, e);
    end
  endtask

  task automatic check32(string name, logic [31:0] a, bit [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, a, e);
    end
  endtask

  task automatic add_trap(bit [1:0] cause, int n);
    for (int i = 0; i < n; i++) push(1, 1, i[0], 1, 5'b10101, ev(0,0,0,0,0,0,0,1,cause));
  endtask

  task automatic add_idle(bit hl);
    push(1, 1, 1, hl, 5'b11111, '0);
  endtask

  task automatic add_halted(int n);
    for (int i = 0; i < n; i++) push(1, 1, 0, 1, '0, '0);
    push(1, 1, 0, 0, '0, '0);
  endtask

  // One instruction as a cycle trace; irrelevant inputs carry noise that must be ignored.
  task automatic add_instr(bit [4:0] cls, bit tk, int idly, int ddly, bit hl_wb, bit cut);
    int nw;
    bit st;
    nw = (idly >= int'(TMO)) ? int'(TMO) : idly;
    for (int i = 0; i < nw; i++) push(0, 1, 0, 1, '0, ev(1,0,0,0,0,0,0,0,0));
    if (idly >= int'(TMO)) begin add_trap(2'd2, 3); return; end
    push(1, 0, 0, 1, '0, ev(1,1,0,0,0,0,0,0,0));
    push(1, 1, !tk, 1, cls, '0);
    if ($countones(cls) != 1) begin add_trap(2'd1, 3); return; end
    push(1, 1, tk, 1, 5'b11111, '0);
    if (cls[3] || cls[2]) begin
      st = cls[2];
      nw = (ddly >= int'(TMO)) ? int'(TMO) : ddly;
      for (int i = 0; i < nw; i++) push(1, 0, !tk, 1, 5'b11111, ev(0,0,1,st,0,0,0,0,0));
      if (cut) return;
      if (ddly >= int'(TMO)) begin add_trap(2'd3, 3); return; end
      push(0, 1, !tk, 1, 5'b11111, ev(0,0,1,st,0,0,0,0,0));
    end
    push(1, 1, !tk, hl_wb, 5'b11111,
         ev(0,0,0,0, cls[4] | cls[3] | cls[0], 1, cls[0] | (cls[1] & tk), 0, 0));
  endtask

  task automatic run_rows();
    row_t       r;
    logic [9:0] o;
    int         idx;
    idx = 0;
    obs.delete();
    while (q.size() > 0) begin
      r = q.pop_front();
      imem_valid   = r.iv;
      dmem_valid   = r.dv;
      branch_taken = r.tk;
      halt         = r.hl;
      {dec_alu, dec_load, dec_store, dec_branch, dec_jump} = r.cls;
      @(negedge clk);
      o = outv();
      obs.push_back(o);
      tests++;
      if (o !== r.exp) begin
        fails++;
        $display("FAIL row%0d outputs: got %b expected %b", idx, o, r.exp);
      end
`ifdef CORE_CONTROLLER_PERF_EN
      check32("perf_cycles", perf_cycles, m_cycles);
      check32("perf_instret", perf_instret, m_instret);
      if (!r.exp[2]) m_cycles++;
      if (r.exp[4])  m_instret++;
`else
      check32("perf_off", perf_cycles | perf_instret, 32'd0);
`endif
      idx++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rstn       = 1'b0;
    imem_valid = 1'b1;
    dmem_valid = 1'b1;
    #1;
    check32("reset_outputs", 32'(outv()), 32'd0);
    check32("reset_perf", perf_cycles | perf_instret, 32'd0);
    m_cycles  = 0;
    m_instret = 0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  initial begin
    #1;
    do_reset();

    // Three back-to-back zero-wait ALU instructions
    add_idle(0);
    for (int i = 0; i < 3; i++) add_instr(C_ALU, 0, 0, 0, 0, 0);
    run_rows();
    check1("alu_irwe_c1",  obs[1][8], 1'b1);
    check1("alu_rwe_c4",   obs[4][5], 1'b1);
    check1("alu_pcwe_c4",  obs[4][4], 1'b1);
    check1("alu_pcsel_c4", obs[4][3], 1'b0);
    check1("alu_ireq_c5",  obs[5][9], 1'b1);
`ifdef CORE_CONTROLLER_PERF_EN
    check32("instret_after_3", perf_instret, 32'd3);
    check32("cycles_after_3",  perf_cycles,  32'd13);
`endif

    // Branches, jump, delayed memory, boundary fetch wait, halt at WB
    add_instr(C_BR,    1, 0, 0, 0, 0);
    add_instr(C_BR,    0, 0, 0, 0, 0);
    add_instr(C_JMP,   0, 0, 0, 0, 0);
    add_instr(C_LOAD,  0, 0, 3, 0, 0);
    add_instr(C_STORE, 1, 1, 1, 0, 0);
    add_instr(C_ALU,   0, 3, 0, 0, 0);
    add_instr(C_STORE, 0, 0, 0, 1, 0);
    add_halted(2);
    add_instr(C_ALU,   0, 0, 0, 0, 0);
    run_rows();
    check1("brt_pcsel", obs[3][3], 1'b1);
    check1("brt_rwe",   obs[3][5], 1'b0);
    check1("brn_pcsel", obs[7][3], 1'b0);
    check1("brn_pcwe",  obs[7][4], 1'b1);
    for (int i = 15; i <= 18; i++) check1("ld_dreq_held", obs[i][7], 1'b1);
    check1("ld_dwe",    obs[18][6], 1'b0);
    check1("ld_rwe",    obs[19][5], 1'b1);
    check1("st_dwe",    obs[25][6], 1'b1);
    check1("st_rwe",    obs[26][5], 1'b0);

    // Illegal class: two flags, then no flags
    add_instr(C_LOAD | C_STORE, 0, 0, 0, 0, 0);
    run_rows();
    check1("ill2_trap", obs[2][2], 1'b1);
    check32("ill2_cause", 32'(obs[2][1:0]), 32'd1);
    do_reset();
    add_idle(0);
    add_instr(5'b00000, 0, 0, 0, 0, 0);
    run_rows();
    check32("ill0_cause", 32'(obs[3][1:0]), 32'd1);

    // Fetch timeout
    do_reset();
    add_idle(0);
    add_instr(C_ALU, 0, TMO, 0, 0, 0);
    run_rows();
    check1("ito_notrap_c4", obs[4][2], 1'b0);
    check32("ito_cause", 32'(obs[5][1:0]), 32'd2);

    // Data timeout
    do_reset();
    add_idle(0);
    add_instr(C_LOAD, 0, 0, TMO, 0, 0);
    run_rows();
    check32("dto_cause", 32'(obs[8][1:0]), 32'd3);

    // Halt from IDLE, then reset in the middle of a load's MEM wait
    do_reset();
    add_idle(1);
    add_halted(1);
    add_instr(C_JMP,  0, 0, 0, 0, 0);
    add_instr(C_LOAD, 0, 0, 2, 0, 1);
    run_rows();
    check1("halt_idle_ireq", obs[1][9], 1'b0);
    check1("resume_ireq",    obs[3][9], 1'b1);
    check1("premid_dreq",    obs[10][7], 1'b1);
    do_reset();
    add_idle(0);
    add_instr(C_ALU, 0, 0, 0, 0, 0);
    run_rows();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
